// File: rtl/ram_64_pkg.sv
// Shared constants and types for the 64-word RAM.
// Banked as eight 8-word blocks selected by the upper address bits.
package ram_64_pkg;

  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 6;
  localparam int BANK_ADDR_W = 3;
  localparam int BANK_DEPTH  = 1 << BANK_ADDR_W;

  typedef logic [WORD_W-1:0]      word_t;
  typedef logic [ADDR_W-1:0]      addr_t;
  typedef logic [BANK_ADDR_W-1:0] bank_addr_t;

  // Upper address bits pick the bank.
  function automatic bank_addr_t bank_of(addr_t a);
    return a[ADDR_W-1:BANK_ADDR_W];
  endfunction

  // Lower address bits pick the word inside a bank.
  function automatic bank_addr_t word_of(addr_t a);
    return a[BANK_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/ram_64_ram_8.sv
// Eight-word register bank with async clear.
// Combinational read, single-edge write.
module ram_8
  import ram_64_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [BANK_ADDR_W-1:0] address,
  output logic [WIDTH-1:0]       out
);

  logic [WIDTH-1:0] mem_q [BANK_DEPTH];
  logic [WIDTH-1:0] mem_d [BANK_DEPTH];

  // Next state: only the addressed word takes the write data.
  always_comb begin
    mem_d = mem_q;
    if (load) begin
      mem_d[address] = in;
    end
  end

  // Storage: reset clears every word without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BANK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read path: straight from the flops, never bypassed from in.
  always_comb begin
    out = mem_q[address];
  end

endmodule

// File: rtl/ram_64.sv
// 64-word RAM built from eight ram_8 banks.
// Load is steered to one bank; read muxes the banks.
module ram_64
  import ram_64_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);

  localparam int NUM_BANKS = DEPTH / BANK_DEPTH;

  bank_addr_t       bank_sel;
  bank_addr_t       word_sel;
  logic             bank_load [NUM_BANKS];
  logic [WIDTH-1:0] bank_out  [NUM_BANKS];

  assign bank_sel = bank_of(address);
  assign word_sel = word_of(address);

  // Demux: only the selected bank sees load.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_load[b] = load && (bank_sel == bank_addr_t'(b));
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    ram_8 #(
      .WIDTH(WIDTH)
    ) u_ram_8 (
      .clk    (clk),
      .rst    (rst),
      .in     (in),
      .load   (bank_load[g]),
      .address(word_sel),
      .out    (bank_out[g])
    );
  end

  // Read mux across banks.
  always_comb begin
    out = bank_out[bank_sel];
  end

endmodule

// File: tb/tb_ram_64.sv
// Self-checking bench for ram_64.
// Array model plus directed literal checks.
module tb_ram_64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic        load;
  logic [5:0]  address;
  logic [15:0] out;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [15:0] model [64];

  ram_64 dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .load   (load),
    .address(address),
    .out    (out)
  );

  always #5 clk = ~clk;

  // Reference memory: async clear, write on clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) model[i] <= 16'h0000;
    end else if (load) begin
      model[address] <= in;
    end
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: addr=%0d got %h expected %h",
               name, address, act, exp);
    end
  endtask

  // Every negedge: read data must match the model.
  always @(negedge clk) begin
    if (chk_en) check("model", out, model[address]);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    load = 1'b1;
    address = a;
    in = d;
    tick();
    load = 1'b0;
  endtask

  task automatic rd(string name, input logic [5:0] a,
                    input logic [15:0] exp);
    address = a;
    #1;
    check(name, out, exp);
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    address = 6'd0;
    in = 16'h0000;
    for (int i = 0; i < 64; i++) model[i] = 16'h0000;
    tick();
    tick();
    rd("rst_out0", 6'd0, 16'h0000);
    rd("rst_out63", 6'd63, 16'h0000);
    rst = 1'b0;
    tick();
    chk_en = 1'b1;

    // Basic write then hold with in cleared.
    wr(6'd10, 16'hBEEF);
    in = 16'h0000;
    tick();
    rd("wr10", 6'd10, 16'hBEEF);

    // Boundary addresses.
    wr(6'd0, 16'h1234);
    wr(6'd63, 16'hABCD);
    rd("rd0", 6'd0, 16'h1234);
    rd("rd63", 6'd63, 16'hABCD);
    rd("rd10", 6'd10, 16'hBEEF);
    for (int a = 1; a < 63; a++) begin
      if (a != 10) rd("others", 6'(a), 16'h0000);
    end

    // Across the bank 0 / bank 1 boundary.
    wr(6'd7, 16'h5555);
    wr(6'd8, 16'hAAAA);
    rd("rd7", 6'd7, 16'h5555);
    rd("rd8", 6'd8, 16'hAAAA);
    rd("rd6", 6'd6, 16'h0000);
    rd("rd9", 6'd9, 16'h0000);

    // Hold with load low and garbage on in.
    load = 1'b0;
    in = 16'hFFFF;
    address = 6'd10;
    repeat (3) tick();
    rd("hold10", 6'd10, 16'hBEEF);

    // Read-during-write: old before edge, new after.
    load = 1'b1;
    address = 6'd20;
    in = 16'h0F0F;
    #7;
    check("rdw_pre", out, 16'h0000);
    @(posedge clk);
    #1;
    check("rdw_post", out, 16'h0F0F);
    load = 1'b0;
    #1;

    // Pending write, then async reset mid-cycle.
    tick();
    load = 1'b1;
    address = 6'd10;
    in = 16'h1111;
    #1;
    rst = 1'b1;
    #1;
    check("arst10", out, 16'h0000);
    rd("arst20", 6'd20, 16'h0000);
    address = 6'd10;
    tick();
    rd("rst_blk", 6'd10, 16'h0000);
    rst = 1'b0;
    load = 1'b0;
    tick();
    rd("post_rst10", 6'd10, 16'h0000);
    rd("post_rst63", 6'd63, 16'h0000);

    // First write after release lands normally.
    wr(6'd5, 16'hCAFE);
    rd("wr5", 6'd5, 16'hCAFE);
    rd("rd4", 6'd4, 16'h0000);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
